// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU, the result stage and its consumer.
// The master side is the producer/consumer environment; the stage uses slave.
interface alu_result_stage_if #(
    parameter int W     = 4,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [W-1:0]  in_y;
    logic          in_cout;
    logic          in_neg;
    logic          in_zero;
    logic          in_overflow;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_op;
    logic [W-1:0]  out_y;
    logic [3:0]    out_flags;
    logic [W-1:0]  acc;
    logic [3:0]    sticky;
    logic          flag_err;
    logic          sticky_clr;
    logic [CW-1:0] count;

    modport master (
        output in_valid, in_op, in_y, in_cout, in_neg, in_zero,
        output in_overflow, out_ready, sticky_clr,
        input  in_ready, out_valid, out_op, out_y, out_flags,
        input  acc, sticky, flag_err, count
    );

    modport slave (
        input  in_valid, in_op, in_y, in_cout, in_neg, in_zero,
        input  in_overflow, out_ready, sticky_clr,
        output in_ready, out_valid, out_op, out_y, out_flags,
        output acc, sticky, flag_err, count
    );
endinterface

// File: rtl/alu_result_stage.sv
// ALU result capture stage: small FIFO of {op, y, flags} with an
// accumulator of the last accepted y, sticky flags and a flag-check bit.
module alu_result_stage #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    alu_result_stage_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef struct packed {
        logic [3:0]   op;
        logic [W-1:0] y;
        logic [3:0]   flags;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          push;
    logic          pop;
    logic [3:0]    in_flags;
    logic          bad_flags;

    assign in_flags = {bus.in_overflow, bus.in_zero,
                       bus.in_neg, bus.in_cout};

    // Zero must mirror y; carry/neg/overflow only make sense for add/sub ops.
    assign bad_flags =
        (bus.in_zero != (bus.in_y == '0)) ||
        ((bus.in_op[1:0] != 2'b11) &&
         (bus.in_cout || bus.in_neg || bus.in_overflow));

    assign bus.in_ready  = !rst && (cnt < FULL);
    assign bus.out_valid = (cnt != '0);
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    assign head          = mem[rd_ptr];
    assign bus.out_op    = head.op;
    assign bus.out_y     = head.y;
    assign bus.out_flags = head.flags;
    assign bus.count     = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{op: bus.in_op, y: bus.in_y,
                                 flags: in_flags};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (pop && !push) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Clear applies first, so a same-cycle push re-seeds sticky and flag_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.acc      <= '0;
            bus.sticky   <= '0;
            bus.flag_err <= 1'b0;
        end else if (push) begin
            bus.acc      <= bus.in_y;
            bus.sticky   <= (bus.sticky_clr ? 4'b0 : bus.sticky) | in_flags;
            bus.flag_err <= (bus.sticky_clr ? 1'b0 : bus.flag_err) | bad_flags;
        end else if (bus.sticky_clr) begin
            bus.sticky   <= '0;
            bus.flag_err <= 1'b0;
        end
    end
endmodule
